// File: rtl/ahb_arb_pkg.sv
// Shared types, HTRANS encodings and the round-robin pick function for the
// AHB-Lite master arbiter.
package ahb_arb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam int MAX_MASTERS = 8;
  localparam int PICK_W      = $clog2(MAX_MASTERS);

  typedef enum logic {
    PARK,
    OWN
  } arb_state_t;

  typedef struct packed {
    logic              found;
    logic [PICK_W-1:0] idx;
  } rr_pick_t;

  // Scan ptr+1, ptr+2, ... modulo n; the master at ptr is examined last.
  function automatic rr_pick_t rr_pick(input logic [MAX_MASTERS-1:0] req,
                                       input logic [PICK_W-1:0]      ptr,
                                       input int unsigned            n);
    rr_pick_t    r;
    int unsigned idx;
    r.found = 1'b0;
    r.idx   = '0;
    for (int unsigned k = 1; k <= MAX_MASTERS; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if (k <= n && !r.found && req[idx]) begin
        r.found = 1'b1;
        r.idx   = PICK_W'(idx);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Purely combinational round-robin winner selection from a request vector
// and the last-winner pointer.
module rr_arbiter_core
  import ahb_arb_pkg::*;
#(
  parameter  int NUM_MASTERS = 2,
  localparam int MW          = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [MW-1:0]          ptr_i,
  output logic [MW-1:0]          winner_o,
  output logic                   found_o
);

  logic [MAX_MASTERS-1:0] req_ext;
  rr_pick_t               pick;
  logic                   unused_pick;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    req_ext                   = '0;
    req_ext[NUM_MASTERS-1:0]  = req_i;
    pick                      = rr_pick(req_ext, PICK_W'(ptr_i), NUM_MASTERS);
    winner_o                  = MW'(pick.idx);
    found_o                   = pick.found;
  end

  // Index bits above MW are always zero for small configurations.
  assign unused_pick = ^pick;

endmodule

// File: rtl/ahb_master_arbiter.sv
// Round-robin AHB-Lite arbiter/multiplexer sharing one slave path between
// NUM_MASTERS masters. Optional bus locking is enabled with `define ARB_LOCK_EN.
module ahb_master_arbiter
  import ahb_arb_pkg::*;
#(
  parameter  int NUM_MASTERS = 2,
  parameter  int ADDR_WIDTH  = 32,
  parameter  int DATA_WIDTH  = 32,
  localparam int MW          = $clog2(NUM_MASTERS)
) (
  input  logic                              HCLK,
  input  logic                              HRESET,
  input  logic [NUM_MASTERS-1:0]            HBUSREQ,
  output logic [NUM_MASTERS-1:0]            HGRANT,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] HADDR_M,
  input  logic [NUM_MASTERS*2-1:0]          HTRANS_M,
  input  logic [NUM_MASTERS-1:0]            HWRITE_M,
  input  logic [NUM_MASTERS*3-1:0]          HSIZE_M,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] HWDATA_M,
  input  logic [NUM_MASTERS-1:0]            HMASTLOCK_M,
  output logic [ADDR_WIDTH-1:0]             HADDR,
  output logic [1:0]                        HTRANS,
  output logic                              HWRITE,
  output logic [2:0]                        HSIZE,
  output logic [DATA_WIDTH-1:0]             HWDATA,
  input  logic                              HREADY,
`ifdef ARB_LOCK_EN
  output logic                              HMASTLOCK,
`endif
  output logic [MW-1:0]                     HMASTER,
  output logic [MW-1:0]                     HMASTER_D
);

  arb_state_t             state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [MW-1:0]          master_q;
  logic [MW-1:0]          master_dp_q;
  logic [MW-1:0]          rr_ptr_q;
  logic                   dphase_valid_q;

  logic [MW-1:0]          winner;
  logic                   found;
  logic                   at_rp;
  logic                   hold_grant;

  assign HGRANT    = grant_q;
  assign HMASTER   = master_q;
  assign HMASTER_D = master_dp_q;

  assign HADDR  = HADDR_M[master_q*ADDR_WIDTH +: ADDR_WIDTH];
  assign HTRANS = HTRANS_M[master_q*2 +: 2];
  assign HWRITE = HWRITE_M[master_q];
  assign HSIZE  = HSIZE_M[master_q*3 +: 3];
  assign HWDATA = HWDATA_M[master_dp_q*DATA_WIDTH +: DATA_WIDTH];

  // Only an accepted transfer that does not continue a burst may hand over.
  assign at_rp = HREADY && (HTRANS != HTRANS_SEQ) && (HTRANS != HTRANS_BUSY);

  rr_arbiter_core #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_core (
    .req_i   (HBUSREQ),
    .ptr_i   (rr_ptr_q),
    .winner_o(winner),
    .found_o (found)
  );

`ifdef ARB_LOCK_EN
  logic locked_q;
  logic locked_d;

  assign HMASTLOCK = HMASTLOCK_M[master_q];

  // Unlocking still keeps the grant for the transfer that carried the unlock.
  always_comb begin
    hold_grant = 1'b0;
    locked_d   = locked_q;
    if (at_rp) begin
      if (HMASTLOCK && HTRANS[1]) begin
        hold_grant = 1'b1;
        locked_d   = 1'b1;
      end else if (locked_q) begin
        hold_grant = 1'b1;
        locked_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) locked_q <= 1'b0;
    else        locked_q <= locked_d;
  end
`else
  logic unused_lock;
  assign hold_grant  = 1'b0;
  assign unused_lock = ^HMASTLOCK_M;
`endif

  always_ff @(posedge HCLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (HRESET) begin
      state_q        <= PARK;
      grant_q        <= NUM_MASTERS'(1);
      master_q       <= '0;
      master_dp_q    <= '0;
      rr_ptr_q       <= '0;
      dphase_valid_q <= 1'b0;
    end else begin
      if (HREADY) begin
        master_dp_q    <= master_q;
        dphase_valid_q <= HTRANS[1];
      end
      if (at_rp && !hold_grant) begin
        if (found) begin
          state_q  <= OWN;
          grant_q  <= NUM_MASTERS'(1) << winner;
          master_q <= winner;
          rr_ptr_q <= winner;
        end else begin
          state_q  <= PARK;
          grant_q  <= NUM_MASTERS'(1);
          master_q <= '0;
        end
      end
    end
  end

  // Arbitration state and data-phase validity are kept for trace visibility only.
  logic unused_trace;
  assign unused_trace = dphase_valid_q ^ (state_q == OWN);

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a rule-level arbitration model.
module tb_ahb_master_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = $clog2(N);

  logic              HCLK = 1'b0;
  logic              HRESET;
  logic [N-1:0]      HBUSREQ;
  logic [N-1:0]      HGRANT;
  logic [N*AW-1:0]   HADDR_M;
  logic [N*2-1:0]    HTRANS_M;
  logic [N-1:0]      HWRITE_M;
  logic [N*3-1:0]    HSIZE_M;
  logic [N*DW-1:0]   HWDATA_M;
  logic [N-1:0]      HMASTLOCK_M;
  logic [AW-1:0]     HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [DW-1:0]     HWDATA;
  logic              HREADY;
  logic [MW-1:0]     HMASTER;
  logic [MW-1:0]     HMASTER_D;
`ifdef ARB_LOCK_EN
  logic              HMASTLOCK;
`endif

  always #5 HCLK = ~HCLK;

  ahb_master_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HBUSREQ(HBUSREQ), .HGRANT(HGRANT),
    .HADDR_M(HADDR_M), .HTRANS_M(HTRANS_M), .HWRITE_M(HWRITE_M),
    .HSIZE_M(HSIZE_M), .HWDATA_M(HWDATA_M), .HMASTLOCK_M(HMASTLOCK_M),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HREADY(HREADY),
`ifdef ARB_LOCK_EN
    .HMASTLOCK(HMASTLOCK),
`endif
    .HMASTER(HMASTER), .HMASTER_D(HMASTER_D)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: owner, last winner, data-phase owner, lock state.
  int m_owner, m_ptr, m_downer;
  bit m_locked;

  task automatic set_m(input int i, input logic [1:0] tr, input logic [31:0] addr,
                       input logic [31:0] wd);
    HTRANS_M[i*2 +: 2]  = tr;
    HADDR_M[i*AW +: AW] = addr;
    HWDATA_M[i*DW +: DW] = wd;
  endtask

  // Advance model with the inputs currently driven, then clock the DUT.
  task automatic tick();
    logic [1:0] tr;
    bit         rp, hold;
    int         idx;
    if (HRESET) begin
      m_owner = 0; m_ptr = 0; m_downer = 0; m_locked = 0;
    end else begin
      tr   = HTRANS_M[m_owner*2 +: 2];
      rp   = HREADY && (tr != 2'b11) && (tr != 2'b01);
      hold = 0;
`ifdef ARB_LOCK_EN
      if (rp) begin
        if (HMASTLOCK_M[m_owner] && tr[1]) begin hold = 1; m_locked = 1; end
        else if (m_locked) begin hold = 1; m_locked = 0; end
      end
`endif
      if (HREADY) m_downer = m_owner;
      if (rp && !hold) begin
        m_owner = 0;
        for (int k = 1; k <= N; k++) begin
          idx = (m_ptr + k) % N;
          if (HBUSREQ[idx]) begin
            m_owner = idx; m_ptr = idx;
            break;
          end
        end
      end
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    HRESET = 1'b1; HBUSREQ = '0; HREADY = 1'b1;
    HADDR_M = '0; HTRANS_M = '0; HWRITE_M = '0; HSIZE_M = '0;
    HWDATA_M = '0; HMASTLOCK_M = '0;
    tick(); tick();
    HRESET = 1'b0;
  endtask

  task automatic test_reset();
    HRESET = 1'b1; HBUSREQ = '0; HREADY = 1'b1;
    HWRITE_M = '0; HSIZE_M = '0; HMASTLOCK_M = '0;
    set_m(0, 2'b00, 32'h1000_0000, 32'h0);
    set_m(1, 2'b10, 32'h2000_0000, 32'h0);
    tick(); tick();
    checks++; if (HGRANT !== 2'b01) begin errors++; $display("FAIL reset_grant: got %b want 01", HGRANT); end
    checks++; if (HMASTER !== 1'b0) begin errors++; $display("FAIL reset_hmaster: got %0d want 0", HMASTER); end
    checks++; if (HMASTER_D !== 1'b0) begin errors++; $display("FAIL reset_hmaster_d: got %0d want 0", HMASTER_D); end
    checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL reset_htrans: got %b want 00", HTRANS); end
    checks++; if (HADDR !== 32'h1000_0000) begin errors++; $display("FAIL reset_haddr: got %h want 10000000", HADDR); end
    HRESET = 1'b0;
  endtask

  task automatic test_single_master();
    do_reset();
    set_m(1, 2'b10, 32'h4000_0010, 32'hA5A5_0001);
    HBUSREQ = 2'b10;
    tick();
    checks++; if (HGRANT !== 2'b10) begin errors++; $display("FAIL single_grant: got %b want 10", HGRANT); end
    checks++; if (HMASTER !== 1'b1) begin errors++; $display("FAIL single_hmaster: got %0d want 1", HMASTER); end
    checks++; if (HADDR !== 32'h4000_0010) begin errors++; $display("FAIL single_haddr: got %h want 40000010", HADDR); end
    checks++; if (HMASTER_D !== 1'b0) begin errors++; $display("FAIL single_dphase_early: got %0d want 0", HMASTER_D); end
    tick();
    checks++; if (HMASTER_D !== 1'b1) begin errors++; $display("FAIL single_hmaster_d: got %0d want 1", HMASTER_D); end
    checks++; if (HWDATA !== 32'hA5A5_0001) begin errors++; $display("FAIL single_hwdata: got %h want a5a50001", HWDATA); end
    checks++; if (HGRANT !== 2'b10) begin errors++; $display("FAIL single_keep: got %b want 10", HGRANT); end
  endtask

  task automatic test_contention();
    logic exp;
    do_reset();
    set_m(0, 2'b10, 32'h0000_0100, 32'h0);
    set_m(1, 2'b10, 32'h0000_0200, 32'h0);
    HBUSREQ = 2'b11;
    exp = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (HMASTER !== exp) begin
        errors++; $display("FAIL contention_%0d: got %0d want %0d", i, HMASTER, exp);
      end
      exp = ~exp;
    end
  endtask

  task automatic test_burst();
    do_reset();
    HBUSREQ = 2'b01;
    tick();
    set_m(0, 2'b10, 32'h0000_1000, 32'h0);
    set_m(1, 2'b10, 32'h0000_2000, 32'h0);
    tick();
    checks++; if (HGRANT !== 2'b01) begin errors++; $display("FAIL burst_beat0: got %b want 01", HGRANT); end
    HBUSREQ = 2'b11;
    for (int b = 1; b < 4; b++) begin
      set_m(0, 2'b11, 32'h0000_1000 + 32'(b*4), 32'h0);
      tick();
      checks++;
      if (HGRANT !== 2'b01) begin errors++; $display("FAIL burst_beat%0d: got %b want 01", b, HGRANT); end
    end
    set_m(0, 2'b00, 32'h0, 32'h0);
    HBUSREQ = 2'b10;
    tick();
    checks++; if (HGRANT !== 2'b10) begin errors++; $display("FAIL burst_handover: got %b want 10", HGRANT); end
  endtask

  task automatic test_wait_states();
    do_reset();
    set_m(1, 2'b10, 32'h0000_3000, 32'h0);
    set_m(0, 2'b00, 32'h0000_4000, 32'h0);
    HBUSREQ = 2'b10;
    tick(); tick();
    HBUSREQ = 2'b11; HREADY = 1'b0;
    for (int w = 0; w < 3; w++) begin
      tick();
      checks++;
      if (HGRANT !== 2'b10 || HMASTER !== 1'b1 || HMASTER_D !== 1'b1) begin
        errors++;
        $display("FAIL wait_%0d: grant=%b master=%0d master_d=%0d want 10/1/1", w, HGRANT, HMASTER, HMASTER_D);
      end
    end
    HREADY = 1'b1;
    tick();
    checks++;
    if (HGRANT !== 2'b01 || HMASTER !== 1'b0 || HMASTER_D !== 1'b1) begin
      errors++;
      $display("FAIL wait_release: grant=%b master=%0d master_d=%0d want 01/0/1", HGRANT, HMASTER, HMASTER_D);
    end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    HBUSREQ = 2'b01;
    tick();
    HBUSREQ = 2'b11;
    set_m(0, 2'b10, 32'h0000_5000, 32'h0);
    set_m(1, 2'b10, 32'h0000_6000, 32'h0);
    HMASTLOCK_M = 2'b01;
    for (int t = 0; t < 3; t++) begin
      tick();
      checks++;
      if (HMASTER !== 1'b0 || HMASTLOCK !== 1'b1) begin
        errors++; $display("FAIL lock_%0d: master=%0d lock=%b want 0/1", t, HMASTER, HMASTLOCK);
      end
    end
    HMASTLOCK_M = 2'b00;
    tick();
    checks++; if (HMASTER !== 1'b0) begin errors++; $display("FAIL lock_unlock_xfer: got %0d want 0", HMASTER); end
    set_m(0, 2'b00, 32'h0, 32'h0);
    tick();
    checks++; if (HGRANT !== 2'b10) begin errors++; $display("FAIL lock_release: got %b want 10", HGRANT); end
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] eg;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      HRESET      = ($urandom_range(0, 49) == 0);
      HBUSREQ     = N'($urandom);
      HREADY      = ($urandom_range(0, 3) != 0);
      HTRANS_M    = (N*2)'($urandom);
      HWRITE_M    = N'($urandom);
      HSIZE_M     = (N*3)'($urandom);
      HMASTLOCK_M = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      HADDR_M     = {$urandom, $urandom};
      HWDATA_M    = {$urandom, $urandom};
      tick();
      eg = '0;
      eg[m_owner] = 1'b1;
      checks++;
      if (HGRANT !== eg || HMASTER !== MW'(m_owner) || HMASTER_D !== MW'(m_downer)) begin
        errors++;
        $display("FAIL rand_arb_%0d: grant=%b master=%0d master_d=%0d want %b/%0d/%0d",
                 c, HGRANT, HMASTER, HMASTER_D, eg, m_owner, m_downer);
      end
      checks++;
      if (HADDR !== HADDR_M[m_owner*AW +: AW] || HTRANS !== HTRANS_M[m_owner*2 +: 2] ||
          HWRITE !== HWRITE_M[m_owner] || HSIZE !== HSIZE_M[m_owner*3 +: 3]) begin
        errors++;
        $display("FAIL rand_amux_%0d: addr=%h trans=%b write=%b size=%b for owner %0d",
                 c, HADDR, HTRANS, HWRITE, HSIZE, m_owner);
      end
      checks++;
      if (HWDATA !== HWDATA_M[m_downer*DW +: DW]) begin
        errors++;
        $display("FAIL rand_wdata_%0d: got %h want %h", c, HWDATA, HWDATA_M[m_downer*DW +: DW]);
      end
    end
    HRESET = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_master();
    test_contention();
    test_burst();
    test_wait_states();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
